// File: rtl/id_exe_stage_reg_if.sv
// Decode-to-execute bundle: decoded word and pipeline controls in,
// registered word and valid flag out.
interface id_exe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
);
    logic              freeze;
    logic              flush;
    logic              bubble;

    logic [3:0]        exe_cmd_in;
    logic              mem_r_en_in;
    logic              mem_w_en_in;
    logic              wb_en_in;
    logic              b_in;
    logic              s_in;
    logic              imm_in;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] val_rn_in;
    logic [DATA_W-1:0] val_rm_in;
    logic [11:0]       shift_op_in;
    logic [23:0]       simm24_in;
    logic [REG_W-1:0]  dest_in;
    logic [REG_W-1:0]  src1_in;
    logic [REG_W-1:0]  src2_in;
    logic              carry_in;

    logic [3:0]        exe_cmd_out;
    logic              mem_r_en_out;
    logic              mem_w_en_out;
    logic              wb_en_out;
    logic              b_out;
    logic              s_out;
    logic              imm_out;
    logic [DATA_W-1:0] pc_out;
    logic [DATA_W-1:0] val_rn_out;
    logic [DATA_W-1:0] val_rm_out;
    logic [11:0]       shift_op_out;
    logic [23:0]       simm24_out;
    logic [REG_W-1:0]  dest_out;
    logic [REG_W-1:0]  src1_out;
    logic [REG_W-1:0]  src2_out;
    logic              carry_out;
    logic              valid_out;

    modport master (
        output freeze, flush, bubble,
        output exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in,
        output b_in, s_in, imm_in, pc_in, val_rn_in, val_rm_in,
        output shift_op_in, simm24_in, dest_in, src1_in, src2_in,
        output carry_in,
        input  exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out,
        input  b_out, s_out, imm_out, pc_out, val_rn_out, val_rm_out,
        input  shift_op_out, simm24_out, dest_out, src1_out, src2_out,
        input  carry_out, valid_out
    );

    modport slave (
        input  freeze, flush, bubble,
        input  exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in,
        input  b_in, s_in, imm_in, pc_in, val_rn_in, val_rm_in,
        input  shift_op_in, simm24_in, dest_in, src1_in, src2_in,
        input  carry_in,
        output exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out,
        output b_out, s_out, imm_out, pc_out, val_rn_out, val_rm_out,
        output shift_op_out, simm24_out, dest_out, src1_out, src2_out,
        output carry_out, valid_out
    );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with freeze, flush and bubble insertion.
// Priority per edge: rst > freeze > flush > bubble > load.
module id_exe_stage_reg (
    input logic         clk,
    input logic         rst,
    id_exe_stage_reg_if.slave bus
);

    logic upd;
    logic cap;

    // Reset always updates; otherwise freeze holds everything.
    // A non-captured update writes an all-zero NOP with valid cleared.
    assign upd = rst || !bus.freeze;
    assign cap = !rst && !bus.flush && !bus.bubble;

    always_ff @(posedge clk) begin
        if (upd) begin
            bus.exe_cmd_out  <= cap ? bus.exe_cmd_in  : '0;
            bus.mem_r_en_out <= cap ? bus.mem_r_en_in : 1'b0;
            bus.mem_w_en_out <= cap ? bus.mem_w_en_in : 1'b0;
            bus.wb_en_out    <= cap ? bus.wb_en_in    : 1'b0;
            bus.b_out        <= cap ? bus.b_in        : 1'b0;
            bus.s_out        <= cap ? bus.s_in        : 1'b0;
            bus.imm_out      <= cap ? bus.imm_in      : 1'b0;
            bus.pc_out       <= cap ? bus.pc_in       : '0;
            bus.val_rn_out   <= cap ? bus.val_rn_in   : '0;
            bus.val_rm_out   <= cap ? bus.val_rm_in   : '0;
            bus.shift_op_out <= cap ? bus.shift_op_in : '0;
            bus.simm24_out   <= cap ? bus.simm24_in   : '0;
            bus.dest_out     <= cap ? bus.dest_in     : '0;
            bus.src1_out     <= cap ? bus.src1_in     : '0;
            bus.src2_out     <= cap ? bus.src2_in     : '0;
            bus.carry_out    <= cap ? bus.carry_in    : 1'b0;
            bus.valid_out    <= cap;
        end
    end

endmodule
